uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with an input FIFO and valid/ready write port.
//  Data width, parity mode and stop-bit count are configurable.
//  Queued words go out back-to-back with no idle gap between frames.
//  Sits between a streaming producer (CPU/DMA/packetiser) and the board TX pin.
// PARAMETERS
//  CLK_FREQ    50_000_000  clock frequency, Hz
//  BAUD        115200      line rate; DIVIDER = CLK_FREQ/BAUD, must be >= 2
//  DATA_BITS   8           payload bits per frame, 5..9, sent LSB first
//  PARITY      PAR_EVEN    PAR_NONE / PAR_EVEN / PAR_ODD (uart_pkg::parity_e)
//  STOP_BITS   1           1 or 2
//  FIFO_DEPTH  8           entries, power of 2, >= 2
// PORTS
//  clk         in   1                       clock
//  reset       in   1                       asynchronous, active-high
//  s_data      in   DATA_BITS               word to transmit
//  s_valid     in   1                       s_data valid
//  s_ready     out  1                       FIFO can accept; write = s_valid & s_ready
//  tx          out  1                       serial line, idle high
//  busy        out  1                       (state != IDLE) | (fifo_level != 0)
//  fifo_level  out  $clog2(FIFO_DEPTH+1)    occupied FIFO entries
//  tx_done     out  1                       1-cycle pulse, last clock of final stop bit
// BEHAVIOUR
//  Reset values: tx=1, s_ready=1, busy=0, fifo_level=0, tx_done=0.
//  Reset is immediate: FIFO flushed, FSM to IDLE, any frame in flight is abandoned.
//  s_ready = !full. It is derived from registered level only, so a full FIFO
//    refuses a push even in a cycle where a pop occurs.
//  Push and pop in the same cycle (not full, not empty): level unchanged.
//  No bypass path. Word accepted at cycle N into an empty FIFO:
//    popped at N+1; tx low from N+2.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//  IDLE: tx=1. If FIFO not empty: pop, load shifter, clear baud counter,
//    go to START.
//  Each state holds tx for exactly DIVIDER clocks.
//    The baud counter restarts at every frame load (not free-running).
//  DATA: DATA_BITS bit periods, LSB first. Bit counter width = $clog2(DATA_BITS+1).
//  PARITY: skipped if PAR_NONE. Even = ^data; odd = ~^data.
//  STOP: STOP_BITS periods of tx=1.
//    On the last clock of the last stop bit, assert tx_done.
//    If FIFO not empty: pop in that same cycle and go directly to START.
//    Otherwise go to IDLE.
//  Frame length = (1 + DATA_BITS + (PARITY!=PAR_NONE) + STOP_BITS) * DIVIDER clocks, exact.
//  s_data is sampled only on accept. Changes while !s_ready are ignored.
//  tx is registered (glitch-free pin).
// STRUCTURE
//  uart_pkg:
//    typedef enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}
//    typedef enum tx_state_e
//    function frame_bits(data_bits, parity, stop_bits)
//  Sub-module uart_fifo_sync: generic synchronous FIFO.
//    Interface: push/pop/full/empty/level, combinational read data.
//  The top level holds the FSM, baud counter, shifter and parity.
//  Elaboration-time assertions on DIVIDER, DATA_BITS, STOP_BITS, FIFO_DEPTH.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> DIVIDER=10)
//  1. Reset asserted then released
//       -> tx=1, s_ready=1, busy=0, fifo_level=0, tx_done=0.
//  2. 8E1, push 0xA5 once
//       -> tx low 2 clocks after accept.
//       -> Bits 0,1,0,1,0,0,1,0,1,0,1, each 10 clocks (110 total).
//       -> tx_done pulses once; busy drops the next cycle.
//  3. 8E1, FIFO_DEPTH=4, s_valid held high with 6 words
//       -> 5 accepted, then s_ready=0.
//       -> Frames contiguous: stop-bit end to next start-bit begin with 0 idle clocks.
//  4. DATA_BITS=7, PAR_ODD, STOP_BITS=2, push 7'h00
//       -> parity bit=1, two stop bits, frame 110 clocks.
//  5. 8N1, push 0xFF
//       -> frame 100 clocks, no parity period.
//  6. Reset pulse mid DATA bit 3 with 2 words queued
//       -> tx=1 asynchronously, fifo_level=0, busy=0.
//       -> After release, a new push of 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Parity selection, transmitter FSM states and frame-length arithmetic.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bit periods in one frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input parity_e     parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready write port of the UART transmitter.
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo_fifo_sync.sv
// Generic synchronous FIFO with combinational read data.
// Push while full and pop while empty are ignored.
module uart_fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  assign level   = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; queued words go out back-to-back.
// Holds the frame FSM, baud counter, shifter and parity; tx is registered.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_e     PARITY     = PAR_EVEN,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  uart_tx_fifo_if.slave                     s,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              tx_done
);
  localparam int unsigned DIVIDER = CLK_FREQ / BAUD;
  localparam int unsigned CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int unsigned BW      = $clog2(DATA_BITS + 1);

  if (DIVIDER < 2) begin : g_chk_divider
    $error("uart_tx_fifo: CLK_FREQ/BAUD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (frame_bits(DATA_BITS, PARITY, STOP_BITS) > 13) begin : g_chk_frame
    $error("uart_tx_fifo: frame longer than 13 bit periods");
  end
  if ($bits(s.s_data) != DATA_BITS) begin : g_chk_if_width
    $error("uart_tx_fifo: interface DATA_BITS differs from module DATA_BITS");
  end

  tx_state_e            state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shifter;
  logic                 par_bit;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 baud_last;
  logic                 pop;

  uart_fifo_sync #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s.s_valid),
    .wdata (s.s_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign s.s_ready = !fifo_full;
  assign baud_last = (baud_cnt == CW'(DIVIDER - 1));
  assign tx_done   = (state == ST_STOP) && baud_last && (bit_cnt == BW'(STOP_BITS - 1));
  // A frame is loaded from IDLE or straight out of the final stop clock, so frames abut.
  assign pop       = !fifo_empty && ((state == ST_IDLE) || tx_done);
  assign busy      = (state != ST_IDLE) || (fifo_level != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else if (pop) begin
      state    <= ST_START;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= fifo_rdata;
      par_bit  <= (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      tx       <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
            tx       <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shifter <= shifter >> 1;
              tx      <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations at DIVIDER=10 checked every cycle
// against a frame-timeline model, plus directed literal expectations.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int NI   = 4;
  localparam int MAXC = 4000;
  localparam int DIV  = 10;
  // inst 0: 8E1 d8, inst 1: 8E1 d4, inst 2: 7O2 d8, inst 3: 8N1 d8
  localparam int DB [NI] = '{8, 8, 7, 8};
  localparam int PM [NI] = '{1, 1, 2, 0};
  localparam int SB [NI] = '{1, 1, 2, 1};
  localparam int DP [NI] = '{8, 4, 8, 8};

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] d_data [NI];
  logic [3:0] d_valid;
  wire  [3:0] tx_o, busy_o, done_o, rdy_o;
  wire  [3:0] lvl0, lvl2, lvl3;
  wire  [2:0] lvl1;

  int checks   = 0;
  int failures = 0;
  int cyc;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if3 ();

  assign if0.s_data  = d_data[0][7:0];
  assign if1.s_data  = d_data[1][7:0];
  assign if2.s_data  = d_data[2][6:0];
  assign if3.s_data  = d_data[3][7:0];
  assign if0.s_valid = d_valid[0];
  assign if1.s_valid = d_valid[1];
  assign if2.s_valid = d_valid[2];
  assign if3.s_valid = d_valid[3];
  assign rdy_o = {if3.s_ready, if2.s_ready, if1.s_ready, if0.s_ready};

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(PAR_EVEN),
                 .STOP_BITS(1), .FIFO_DEPTH(8)) dut0 (
    .clk(clk), .reset(reset), .s(if0), .tx(tx_o[0]), .busy(busy_o[0]),
    .fifo_level(lvl0), .tx_done(done_o[0]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(PAR_EVEN),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .s(if1), .tx(tx_o[1]), .busy(busy_o[1]),
    .fifo_level(lvl1), .tx_done(done_o[1]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(PAR_ODD),
                 .STOP_BITS(2), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .reset(reset), .s(if2), .tx(tx_o[2]), .busy(busy_o[2]),
    .fifo_level(lvl2), .tx_done(done_o[2]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(PAR_NONE),
                 .STOP_BITS(1), .FIFO_DEPTH(8)) dut3 (
    .clk(clk), .reset(reset), .s(if3), .tx(tx_o[3]), .busy(busy_o[3]),
    .fifo_level(lvl3), .tx_done(done_o[3]));

  function automatic int lvl_of(input int i);
    case (i)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      2:       return int'(lvl2);
      default: return int'(lvl3);
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0d expected=%0d", name, inst, cyc, act, exp);
    end
  endtask

  // Model: per-cycle expected line/done/in-frame timelines plus pop cycles.
  bit ex_tx    [NI][MAXC];
  bit ex_done  [NI][MAXC];
  bit ex_frame [NI][MAXC];
  bit ex_pop   [NI][MAXC];
  int mlevel   [NI];
  int prev_end [NI];

  task automatic model_reset(input int i, input int from);
    for (int k = from; k < MAXC; k++) begin
      ex_tx[i][k] = 1'b1; ex_done[i][k] = 1'b0; ex_frame[i][k] = 1'b0; ex_pop[i][k] = 1'b0;
    end
    mlevel[i]   = 0;
    prev_end[i] = -10;
  endtask

  task automatic model_push(input int i, input int c, input logic [8:0] w);
    bit bits[$];
    bit p;
    int s, n;
    s = (c + 2 > prev_end[i] + 1) ? c + 2 : prev_end[i] + 1;
    bits.push_back(1'b0);
    p = 1'b0;
    for (int b = 0; b < DB[i]; b++) begin
      bits.push_back(w[b]);
      p ^= w[b];
    end
    if (PM[i] == 1) bits.push_back(p);
    else if (PM[i] == 2) bits.push_back(!p);
    for (int b = 0; b < SB[i]; b++) bits.push_back(1'b1);
    n = bits.size() * DIV;
    for (int k = 0; k < n; k++)
      if (s + k < MAXC) begin
        ex_tx[i][s+k]    = bits[k / DIV];
        ex_frame[i][s+k] = 1'b1;
      end
    if (s - 1 < MAXC) ex_pop[i][s-1] = 1'b1;
    if (s + n - 1 < MAXC) ex_done[i][s+n-1] = 1'b1;
    prev_end[i] = s + n - 1;
  endtask

  // Compare process: every cycle, every instance, at the falling edge.
  initial begin
    bit acc;
    for (int i = 0; i < NI; i++) model_reset(i, 0);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cyc < MAXC) begin
        for (int i = 0; i < NI; i++) begin
          if (reset) model_reset(i, cyc);
          chk("tx", i, tx_o[i], ex_tx[i][cyc]);
          chk("tx_done", i, done_o[i], ex_done[i][cyc]);
          chk("fifo_level", i, lvl_of(i), mlevel[i]);
          chk("s_ready", i, rdy_o[i], mlevel[i] < DP[i]);
          chk("busy", i, busy_o[i], (mlevel[i] != 0) || ex_frame[i][cyc]);
          if (!reset) begin
            acc = d_valid[i] && (mlevel[i] < DP[i]);
            if (acc) model_push(i, cyc, d_data[i]);
            mlevel[i] = mlevel[i] + int'(acc) - int'(ex_pop[i][cyc]);
          end
        end
      end
      cyc++;
    end
  end

  // Push one word, then follow its frame: length in clocks and mid-bit samples.
  task automatic send_measure(input int i, input logic [8:0] w, output int len,
                              output logic [15:0] samp);
    int n, m;
    samp = '1;
    @(posedge clk); #2;
    d_data[i] = w; d_valid[i] = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    d_valid[i] = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (tx_o[i] && n < 20);
    if (n >= 20) chk("start_timeout", i, 0, 1);
    m = 1;
    while (1) begin
      if (m >= 6 && (m - 6) % 10 == 0 && (m - 6) / 10 < 16) samp[(m-6)/10] = tx_o[i];
      if (done_o[i] || m >= 300) break;
      @(negedge clk); m++;
    end
    len = m;
  endtask

  initial begin
    logic [10:0] a5_bits = 11'b10101001010;
    logic [10:0] x3c_bits = 11'b10001111000;
    logic [8:0]  words3 [6] = '{9'h011, 9'h0FE, 9'h080, 9'h001, 9'h05A, 9'h0C3};
    logic [15:0] samp;
    int len, acc_cnt, dn;

    reset = 1'b1; d_valid = '0;
    for (int i = 0; i < NI; i++) d_data[i] = '0;

    // 1: reset values
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_tx", i, tx_o[i], 1); chk("rst_ready", i, rdy_o[i], 1);
      chk("rst_busy", i, busy_o[i], 0); chk("rst_level", i, lvl_of(i), 0);
      chk("rst_done", i, done_o[i], 0);
    end

    // 2: 8E1 0xA5
    @(posedge clk); #2;
    d_data[0] = 9'h0A5; d_valid[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    d_valid[0] = 1'b0;
    @(negedge clk);
    chk("t2_pre_start", 0, tx_o[0], 1);
    @(negedge clk);
    chk("t2_start_low", 0, tx_o[0], 0);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      chk("t2_bit", k, tx_o[0], a5_bits[k]);
      if (k < 10) repeat (10) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("t2_done", 0, done_o[0], 1);
    chk("t2_busy_last", 0, busy_o[0], 1);
    @(negedge clk);
    chk("t2_done_once", 0, done_o[0], 0);
    chk("t2_busy_drop", 0, busy_o[0], 0);

    // 3: depth 4, valid held for 6 words
    acc_cnt = 0; dn = 0;
    @(posedge clk); #2;
    d_data[1] = words3[0]; d_valid[1] = 1'b1;
    for (int k = 0; k < 400 && acc_cnt < 6; k++) begin
      @(negedge clk);
      if (done_o[1]) dn++;
      if (rdy_o[1]) acc_cnt++;
      if (k == 7) begin
        chk("t3_accepted", 1, acc_cnt, 5);
        chk("t3_ready_low", 1, rdy_o[1], 0);
      end
      @(posedge clk); #2;
      if (acc_cnt < 6) d_data[1] = words3[acc_cnt];
      else d_valid[1] = 1'b0;
    end
    chk("t3_all_accepted", 1, acc_cnt, 6);
    for (int k = 0; k < 1000 && busy_o[1]; k++) begin
      @(negedge clk);
      if (done_o[1]) dn++;
    end
    chk("t3_done_pulses", 1, dn, 6);

    // 4: 7O2 0x00
    send_measure(2, 9'h000, len, samp);
    chk("t4_len", 2, len, 110);
    chk("t4_start", 2, samp[0], 0);
    chk("t4_parity", 2, samp[8], 1);
    chk("t4_stop1", 2, samp[9], 1);
    chk("t4_stop2", 2, samp[10], 1);

    // 5: 8N1 0xFF
    send_measure(3, 9'h0FF, len, samp);
    chk("t5_len", 3, len, 100);
    chk("t5_start", 3, samp[0], 0);
    chk("t5_stop", 3, samp[9], 1);

    // 6: reset in the middle of data bit 3 with two words queued
    @(posedge clk); #2;
    d_data[0] = 9'h011; d_valid[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #2 d_data[0] = 9'h022;
    @(negedge clk);
    @(posedge clk); #2 d_data[0] = 9'h033;
    @(negedge clk);
    @(posedge clk); #2 d_valid[0] = 1'b0;
    repeat (43) @(posedge clk);
    @(negedge clk);
    chk("t6_queued", 0, lvl_of(0), 2);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("t6_async_tx", 0, tx_o[0], 1);
    chk("t6_async_level", 0, lvl_of(0), 0);
    chk("t6_async_busy", 0, busy_o[0], 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    send_measure(0, 9'h03C, len, samp);
    chk("t6_len", 0, len, 110);
    for (int k = 0; k < 11; k++) chk("t6_bit", k, samp[k], x3c_bits[k]);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(MAXC * 10);
    failures++;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
